mips_decode_stage: RTL

//  Registered MIPS decode stage: accepts 32-bit instructions over a valid/ready handshake, decodes ALU control
//  (R-type add/sub/and/or/nor/xor, I-type addi/andi/ori/xori), and presents a registered control bundle downstream.

---
 rtl/mips_defines.sv | 44 ++++
 rtl/mips_decode_stage_core.sv | 52 +++++
 rtl/mips_decode_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_defines.sv
// Shared opcodes, ALU encodings, the decoded control bundle and the buffer state enum
// for the MIPS decode stage.
package mips_defines;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd3;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd4;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd5;
  localparam logic [ALU_W-1:0] ALU_NOR = 3'd6;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'd7;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             alu_src2;
    logic             rd_src;
    logic             we;
    logic             except;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [15:0]      imm;
  } ctrl_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/mips_decode_stage_core.sv
// Pure combinational decode of one instruction word into the control bundle.
module mips_decode_core
  import mips_defines::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = inst[31:26];
  assign funct = inst[5:0];

  always_comb begin
    ctrl     = '0;
    ctrl.rs  = inst[25:21];
    ctrl.rt  = inst[20:16];
    ctrl.rd  = inst[15:11];
    ctrl.imm = inst[15:0];
    case (op)
      OP_OTHER0: begin
        ctrl.we = 1'b1;
        case (funct)
          OP0_ADD: ctrl.alu_op = ALU_ADD;
          OP0_SUB: ctrl.alu_op = ALU_SUB;
          OP0_AND: ctrl.alu_op = ALU_AND;
          OP0_OR:  ctrl.alu_op = ALU_OR;
          OP0_NOR: ctrl.alu_op = ALU_NOR;
          OP0_XOR: ctrl.alu_op = ALU_XOR;
          default: begin
            ctrl.we     = 1'b0;
            ctrl.except = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src2 = 1'b1;
        ctrl.rd_src   = 1'b1;
        ctrl.we       = 1'b1;
        case (op)
          OP_ADDI: ctrl.alu_op = ALU_ADD;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          default: ctrl.alu_op = ALU_XOR;
        endcase
      end
      default: ctrl.except = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage with a 2-entry skid buffer, flush and pass-through tag.
// Define DECODE_EXCEPT_CNT_EN to add the saturating except_count output.
module mips_decode_stage
  import mips_defines::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int TAG_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_alu_src2,
  output logic                out_rd_src,
  output logic                out_writeenable,
  output logic                out_except,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_rd,
  output logic [15:0]         out_imm,
  output logic [TAG_W-1:0]    out_tag
`ifdef DECODE_EXCEPT_CNT_EN
  ,
  output logic [CNT_W-1:0]    except_count
`endif
);

  buf_state_t       state, state_nxt;
  ctrl_t            dec_ctrl, main_ctrl, skid_ctrl;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             accept, emit;
  logic             load_main_in, load_main_skid, load_skid;

  mips_decode_core u_core (
    .inst (in_inst),
    .ctrl (dec_ctrl)
  );

  // in_ready is a pure function of the state register, so it never sees out_ready.
  assign in_ready  = (state != BUF_TWO);
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: if (accept) begin
          state_nxt    = BUF_ONE;
          load_main_in = 1'b1;
        end
        BUF_ONE: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = BUF_TWO;
            load_skid = 1'b1;
          end else if (emit) begin
            state_nxt = BUF_EMPTY;
          end
        end
        BUF_TWO: if (emit) begin
          state_nxt      = BUF_ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_tag  <= '0;
      skid_ctrl <= '0;
      skid_tag  <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= dec_ctrl;
        main_tag  <= in_tag;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_ctrl <= dec_ctrl;
        skid_tag  <= in_tag;
      end
    end
  end

  assign out_alu_op      = ALU_OP_W'(main_ctrl.alu_op);
  assign out_alu_src2    = main_ctrl.alu_src2;
  assign out_rd_src      = main_ctrl.rd_src;
  assign out_writeenable = main_ctrl.we & ~main_ctrl.except;
  assign out_except      = main_ctrl.except;
  assign out_rs          = main_ctrl.rs;
  assign out_rt          = main_ctrl.rt;
  assign out_rd          = main_ctrl.rd;
  assign out_imm         = main_ctrl.imm;
  assign out_tag         = main_tag;

`ifdef DECODE_EXCEPT_CNT_EN
  // A flush overrides the handshake, so an entry presented during flush is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      except_count <= '0;
    else if (emit && !flush && main_ctrl.except && (except_count != {CNT_W{1'b1}}))
      except_count <= except_count + 1'b1;
  end
`endif

endmodule
